// File: rtl/clk_period_meter_if.sv
// Result/handshake bundle between clk_period_meter and its consumer.
// Ports: start/out_ready flow into the meter; busy, meas_valid, period_cnt,
// high_cnt and timeout flow back out. CNT_W must match the meter's CNT_W.
interface clk_period_meter_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             busy;
    logic             meas_valid;
    logic             out_ready;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             timeout;

    // Meter side: consumes requests, produces results.
    modport master (
        input  start,
        input  out_ready,
        output busy,
        output meas_valid,
        output period_cnt,
        output high_cnt,
        output timeout
    );

    // Consumer side: issues requests, accepts results.
    modport slave (
        output start,
        output out_ready,
        input  busy,
        input  meas_valid,
        input  period_cnt,
        input  high_cnt,
        input  timeout
    );
endinterface

// File: rtl/clk_period_meter.sv
// Purpose: measure period and high time of an asynchronous divided clock in clk cycles.
// Latency: result valid SYNC_STAGES+1 cycles after the second sampled rising edge plus one state cycle.
// Backpressure: result held stable on meas_valid until out_ready; no new measurement until accepted.
//
// Ports: clk, rst (async, active-low), div_clk_in (asynchronous input under test),
//        mb (clk_period_meter_if.master): start/out_ready in, busy/meas_valid/period_cnt/
//        high_cnt/timeout out.
// Optional build macro CLK_PERIOD_METER_GLITCH_FILTER_EN inserts a 2-sample majority
// filter after the synchronizer (+1 cycle latency, rejects single-cycle pulses).
// SYNC_STAGES legal range is 2..4.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_clk_in,
    clk_period_meter_if.master mb
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        MEAS_HIGH = 3'd2,
        MEAS_LOW  = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_d;
    logic                   rise;
    logic                   fall;
    logic                   sat;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       high_q;
    logic                   timeout_q;
    logic                   busy_c;
    logic                   valid_c;

    // Synchronizer: bit 0 is the newest sample, the top bit is the settled level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
        end
    end

`ifdef CLK_PERIOD_METER_GLITCH_FILTER_EN
    // The top two synchronizer bits are two consecutive samples of the input;
    // the level only follows them once they agree, so a lone one-cycle pulse
    // never reaches the edge detector.
    logic filt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) begin
            filt_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    // History flop for edge detection; rise and fall can never be high together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise    = lvl & ~lvl_d;
    assign fall    = ~lvl & lvl_d;
    assign sat     = (cnt == CNT_MAX);
    // Counter holds at its maximum rather than wrapping.
    assign cnt_inc = sat ? cnt : cnt + CNT_ONE;

    // FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. The expected edge wins over saturation in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (mb.start)         state_nxt = ARM;
            ARM:       if (rise)             state_nxt = MEAS_HIGH;
                       else if (sat)         state_nxt = DONE;
            MEAS_HIGH: if (fall)             state_nxt = MEAS_LOW;
                       else if (sat)         state_nxt = DONE;
            MEAS_LOW:  if (rise || sat)      state_nxt = DONE;
            DONE:      if (mb.out_ready)     state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. meas_valid is high exactly while the result is held in DONE.
    always_comb begin
        busy_c  = 1'b0;
        valid_c = 1'b0;
        case (state)
            ARM, MEAS_HIGH, MEAS_LOW: busy_c  = 1'b1;
            DONE:                     valid_c = 1'b1;
            default:                  ;
        endcase
    end

    // Datapath: cycle counter and captured results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            period_q  <= '0;
            high_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mb.start) begin
                        cnt       <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        // The rising-edge cycle itself is the first counted cycle.
                        cnt <= CNT_ONE;
                    end else if (sat) begin
                        timeout_q <= 1'b1;
                        period_q  <= CNT_MAX;
                        high_q    <= CNT_MAX;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_q <= cnt;
                        cnt    <= cnt_inc;
                    end else if (sat) begin
                        timeout_q <= 1'b1;
                        period_q  <= CNT_MAX;
                        high_q    <= CNT_MAX;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        period_q <= cnt;
                    end else if (sat) begin
                        // high_q keeps the value captured on the falling edge.
                        timeout_q <= 1'b1;
                        period_q  <= CNT_MAX;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mb.busy       = busy_c;
    assign mb.meas_valid = valid_c;
    assign mb.period_cnt = period_q;
    assign mb.high_cnt   = high_q;
    assign mb.timeout    = timeout_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter (CNT_W=8, SYNC_STAGES=2).
// div_clk_in comes either from a free-running divide-by-2^n counter or a
// hand-driven level; expectations are hand-computed per step.
module tb_clk_period_meter;
    localparam int CW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       div_clk;
    logic       man = 1'b0;
    int         mode = 0;      // 0: manual level, 1: clk/8, 2: clk/2
    logic [2:0] divcnt = '0;
    int         n_checks = 0;
    int         n_err = 0;
    int         lat;

    clk_period_meter_if #(.CNT_W(CW)) bus ();

    clk_period_meter #(
        .CNT_W      (CW),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .div_clk_in(div_clk),
        .mb        (bus)
    );

    always #5 clk = ~clk;

    // Same waveform as a ripple divider chain clocked from clk.
    always @(posedge clk) divcnt <= divcnt + 3'd1;

    assign div_clk = (mode == 1) ? divcnt[2] : (mode == 2) ? divcnt[0] : man;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int bound, output int cycles);
        cycles = 0;
        while (bus.meas_valid !== 1'b1 && cycles < bound) begin
            tick(1);
            cycles++;
        end
        check({tag, " valid"}, 32'(bus.meas_valid), 32'd1);
    endtask

    task automatic expect_result(input string tag, input int p, input int h, input int t);
        check({tag, " period"},  32'(bus.period_cnt), 32'(p));
        check({tag, " high"},    32'(bus.high_cnt),   32'(h));
        check({tag, " timeout"}, 32'(bus.timeout),    32'(t));
    endtask

    task automatic accept(input string tag);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        check({tag, " valid_drop"}, 32'(bus.meas_valid), 32'd0);
        check({tag, " idle_busy"},  32'(bus.busy),       32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        tick(2);
        check("rst busy",    32'(bus.busy),       32'd0);
        check("rst valid",   32'(bus.meas_valid), 32'd0);
        check("rst period",  32'(bus.period_cnt), 32'd0);
        check("rst high",    32'(bus.high_cnt),   32'd0);
        check("rst timeout", 32'(bus.timeout),    32'd0);
        rst = 1'b1;
        tick(2);

        // clk/8: period 8, high 4; result held stable under backpressure.
        mode = 1;
        tick(4);
        pulse_start();
        wait_valid("div8", 200, lat);
        expect_result("div8", 8, 4, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("div8 hold valid",  32'(bus.meas_valid), 32'd1);
            check("div8 hold period", 32'(bus.period_cnt), 32'd8);
            check("div8 hold high",   32'(bus.high_cnt),   32'd4);
        end
        accept("div8");

        // clk/2: one-cycle phases. The glitch filter rejects these entirely.
        mode = 2;
        tick(4);
        pulse_start();
        wait_valid("div2", 400, lat);
`ifdef CLK_PERIOD_METER_GLITCH_FILTER_EN
        expect_result("div2", 255, 255, 1);
`else
        expect_result("div2", 2, 1, 0);
`endif
        accept("div2");

        // Input stuck low: ARM counts 0..255, i.e. 256 cycles, then times out.
        mode = 0;
        man  = 1'b0;
        tick(6);
        pulse_start();
        wait_valid("stuck_low", 400, lat);
        check("stuck_low latency", 32'(lat), 32'd256);
        expect_result("stuck_low", 255, 255, 1);
        accept("stuck_low");

        // Rise then stuck high: times out in MEAS_HIGH.
        pulse_start();
        tick(3);
        man = 1'b1;
        wait_valid("stuck_high", 400, lat);
        expect_result("stuck_high", 255, 255, 1);
        accept("stuck_high");

        // High 10 cycles then stuck low: high captured, period times out.
        man = 1'b0;
        tick(4);
        pulse_start();
        tick(3);
        man = 1'b1;
        tick(10);
        man = 1'b0;
        wait_valid("high10", 400, lat);
        expect_result("high10", 255, 10, 1);
        accept("high10");

        // Asynchronous reset during MEAS_LOW clears everything at once.
        tick(4);
        pulse_start();
        tick(3);
        man = 1'b1;
        tick(5);
        man = 1'b0;
        tick(4);
        check("pre_rst busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst busy",    32'(bus.busy),       32'd0);
        check("mid_rst valid",   32'(bus.meas_valid), 32'd0);
        check("mid_rst period",  32'(bus.period_cnt), 32'd0);
        check("mid_rst high",    32'(bus.high_cnt),   32'd0);
        check("mid_rst timeout", 32'(bus.timeout),    32'd0);
        #1;
        rst = 1'b1;
        tick(2);

        // start while busy is ignored; measurement completes normally.
        mode = 1;
        tick(3);
        pulse_start();
        tick(2);
        check("busy_start busy", 32'(bus.busy), 32'd1);
        pulse_start();
        wait_valid("busy_start", 200, lat);
        expect_result("busy_start", 8, 4, 0);

        // start in the handshake cycle is ignored: meter stays idle.
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        tick(2);
        check("hs_start busy",  32'(bus.busy),       32'd0);
        check("hs_start valid", 32'(bus.meas_valid), 32'd0);

        // A later start gives a fresh, correct measurement.
        pulse_start();
        wait_valid("fresh", 200, lat);
        expect_result("fresh", 8, 4, 0);
        accept("fresh");

        // clk/16 with a one-cycle high glitch at low-phase position 1.
        mode = 0;
        man  = 1'b0;
        tick(5);
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            man = 1'b0;
            tick(1);
            man = 1'b1;
            tick(1);
            man = 1'b0;
            tick(6);
            man = 1'b1;
            tick(8);
        end
        man = 1'b0;
        wait_valid("glitch", 100, lat);
`ifdef CLK_PERIOD_METER_GLITCH_FILTER_EN
        expect_result("glitch", 16, 8, 0);
`else
        // The glitch itself is the first rise: high 1, then 7 cycles to the real rise.
        expect_result("glitch", 7, 1, 0);
`endif
        accept("glitch");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
